lsu_mem_ctrl: RTL and testbench
===============================

# lsu_mem_ctrl

Load/store initiator between the MEM pipeline stage and `data_ram`. Accepts one load or store per handshake, drives the RAM port (`ce`, `we`, `sel`, `addr`, `data_i`), and waits a configurable read latency before capturing `data_o`. It returns sign- or zero-extended load data, or flags a misaligned access. It stalls the pipeline while an access is in flight.

## Interface
- `RD_LATENCY`, 1: cycles `ram_ce` is held for a load before `ram_rdata` is sampled; legal range 1..4.
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req_valid` in 1: MEM stage presents an access; fields held stable until `resp_valid`.
- `req_ready` out 1: block is idle and can accept a request.
- `req_op` in 3: 000 LB, 001 LBU, 010 LH, 011 LHU, 100 LW, 101 SB, 110 SH, 111 SW.
- `req_addr` in ram_addr_t: byte address.
- `req_wdata` in ram_data_t: store data, right-justified.
- `resp_valid` out 1: one-cycle pulse; access complete.
- `resp_rdata` out ram_data_t: extended load data; 0 for stores and errors.
- `resp_err` out 1: misaligned access; valid with `resp_valid`.
- `stall_o` out 1: `req_valid & ~resp_valid`, combinational.
- `ram_ce` out chip_status_t: CHIP_ENABLE during access cycles, otherwise CHIP_DISABLE.
- `ram_we` out 1: write strobe.
- `ram_sel` out 4: byte-lane enables; bit 3 = bits 31:24.
- `ram_addr` out ram_addr_t: word address; the byte address with [1:0] forced to 0.
- `ram_wdata` out ram_data_t: lane-replicated store data.
- `ram_rdata` in ram_data_t: RAM read data.

## Operation
- Big-endian byte order. Byte offset `a = req_addr[1:0]`; offset 0 maps to lane 3 (bits 31:24).
- FSM states: IDLE, ACCESS, RESP.
  - IDLE: `req_ready=1`. On `req_valid`, latch the request.
    - Misaligned request: go to RESP with error.
    - Aligned request: go to ACCESS and load the wait counter with RD_LATENCY-1 for loads, 0 for stores.
  - ACCESS: decrement the counter each cycle. At count 0:
    - Load: capture extended data from `ram_rdata`.
    - Go to RESP in either case.
  - RESP: `resp_valid=1` for one cycle, then go to IDLE. `req_ready=0` in ACCESS and RESP.
- Misalignment rules:
  - LH, LHU, SH are misaligned when `a[0]=1`.
  - LW, SW are misaligned when `a!=0`.
  - Bytes are never misaligned.
  - A misaligned request never asserts `ram_ce` or `ram_we`.
- Stores drive `ram_we=1` for exactly one ACCESS cycle.
  - SB: `ram_sel` = 1000/0100/0010/0001 for a=0/1/2/3; `ram_wdata = {4{wdata[7:0]}}`.
  - SH: `ram_sel` = 1100 for a=0, 0011 for a=2; `ram_wdata = {2{wdata[15:0]}}`.
  - SW: `ram_sel` = 1111; `ram_wdata = wdata`.
- Loads drive `ram_we=0`, `ram_sel=1111`, and hold `ram_addr` constant for all ACCESS cycles.
  - Byte lane: `rdata[31-8a -: 8]`.
  - Halfword lane: `rdata[31:16]` for a=0, `rdata[15:0]` for a=2.
  - LB and LH sign-extend. LBU and LHU zero-extend. LW passes the word through.
- All `ram_*` outputs and all `resp_*` outputs are registered.
- Outside ACCESS: `ram_we=0`, `ram_sel=0`. `ram_addr` and `ram_wdata` hold their last values.

## Timing
- Request accepted at clock edge T (`req_valid & req_ready`).
- Store: ACCESS during cycle T+1, `resp_valid` at T+2.
- Load: ACCESS during cycles T+1 .. T+RD_LATENCY. `ram_rdata` is sampled at the end of the last ACCESS cycle. `resp_valid` at T+RD_LATENCY+1.
- Misaligned access: `resp_valid=1`, `resp_err=1` at T+1.
- Back-to-back requests: a new request is accepted at the earliest in the IDLE cycle after RESP.
  - Minimum spacing is 3 cycles (2 for errors).
  - The requester replaces or drops `req_valid` in the cycle after `resp_valid`.
- Reset values:
  - `ram_ce=CHIP_DISABLE`; `ram_we`, `ram_sel`, `ram_addr`, `ram_wdata` all 0.
  - `resp_valid`, `resp_rdata`, `resp_err` all 0.
  - State IDLE, so `req_ready=1`.
- Reset mid-access:
  - `ram_we` and `ram_ce` drop immediately (asynchronously).
  - The access is abandoned with no `resp_valid`.
  - A partially strobed store has completed or not; no guarantee is made.
- `req_valid` low in IDLE: no RAM activity, `stall_o=0`.

## Test plan
- Reset with `rst_n=0` held over 3 clocks -> all outputs at reset values, `req_ready=1`; release -> no `ram_ce` without a request.
- SB `addr=0x13`, `wdata=0x000000A5` -> one ACCESS cycle with `ram_sel=0001`, `ram_addr=0x10`, `ram_wdata=0xA5A5A5A5`, `ram_we=1`; `resp_valid` at T+2 with `resp_err=0`.
- After RAM word 0x10 holds `0x80FF7F01`:
  - LB at 0x10 -> `0xFFFFFF80`.
  - LBU at 0x10 -> `0x00000080`.
  - LH at 0x12 -> `0x00007F01`.
  - LHU at 0x10 -> `0x000080FF`.
  - LW at 0x10 -> `0x80FF7F01`.
- RD_LATENCY=3, LW -> `ram_ce` asserted for 3 cycles with a constant `ram_addr`; `resp_valid` at T+4; `stall_o` high from T through T+3, low at T+4.
- SW at 0x12 and LH at 0x11 -> `resp_err=1` at T+1; `ram_ce` never CHIP_ENABLE; `resp_rdata=0`.
- LW in flight (RD_LATENCY=2), `rst_n` pulsed low in the first ACCESS cycle -> `ram_ce` drops without waiting for a clock edge, no `resp_valid`, next request served normally.

Source files
------------

// File: rtl/lsu_mem_ctrl_if.sv
// Request/response handshake between the MEM stage (master) and the LSU (slave).
interface lsu_mem_ctrl_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [2:0]        req_op;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_err;
    logic              stall_o;

    modport master (
        output req_valid, req_op, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err, stall_o
    );

    modport slave (
        input  req_valid, req_op, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err, stall_o
    );
endinterface

// File: rtl/lsu_mem_ctrl.sv
// Load/store initiator: one access per handshake to data_ram, big-endian lanes,
// configurable read latency, sign/zero extension and misalignment reporting.
module lsu_mem_ctrl #(
    parameter int RD_LATENCY = 1,
    parameter int ADDR_W     = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    lsu_mem_ctrl_if.slave     bus,
    output logic              ram_ce,
    output logic              ram_we,
    output logic [3:0]        ram_sel,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);
    localparam logic CHIP_ENABLE  = 1'b1;
    localparam logic CHIP_DISABLE = 1'b0;
    localparam logic [1:0] LD_CNT = 2'(RD_LATENCY - 1);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t     state;
    logic [1:0] cnt;
    logic [2:0] op_q;
    logic [1:0] off_q;

    logic [1:0]  a;
    logic        is_load;
    logic        mis;
    logic [3:0]  st_sel;
    logic [31:0] st_data;

    assign a           = bus.req_addr[1:0];
    assign is_load     = (bus.req_op <= 3'd4);
    assign bus.req_ready = (state == IDLE);
    assign bus.stall_o   = bus.req_valid & ~bus.resp_valid;

    // Misalignment and store lane steering; offset 0 is the most significant lane.
    always_comb begin
        mis     = 1'b0;
        st_sel  = 4'b1111;
        st_data = bus.req_wdata;
        case (bus.req_op)
            3'd2, 3'd3: mis = a[0];
            3'd4, 3'd7: mis = |a;
            3'd5: begin
                st_sel  = 4'b1000 >> a;
                st_data = {4{bus.req_wdata[7:0]}};
            end
            3'd6: begin
                mis     = a[0];
                st_sel  = a[1] ? 4'b0011 : 4'b1100;
                st_data = {2{bus.req_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    function automatic logic [31:0] ld_ext(input logic [2:0] op, input logic [1:0] off,
                                           input logic [31:0] rd);
        logic [7:0]  b;
        logic [15:0] h;
        case (off)
            2'd0:    b = rd[31:24];
            2'd1:    b = rd[23:16];
            2'd2:    b = rd[15:8];
            default: b = rd[7:0];
        endcase
        h = off[1] ? rd[15:0] : rd[31:16];
        case (op)
            3'd0:    ld_ext = {{24{b[7]}}, b};
            3'd1:    ld_ext = {24'h0, b};
            3'd2:    ld_ext = {{16{h[15]}}, h};
            3'd3:    ld_ext = {16'h0, h};
            default: ld_ext = rd;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            cnt            <= 2'd0;
            op_q           <= 3'd0;
            off_q          <= 2'd0;
            ram_ce         <= CHIP_DISABLE;
            ram_we         <= 1'b0;
            ram_sel        <= 4'b0;
            ram_addr       <= '0;
            ram_wdata      <= 32'h0;
            bus.resp_valid <= 1'b0;
            bus.resp_rdata <= 32'h0;
            bus.resp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.req_valid) begin
                    op_q  <= bus.req_op;
                    off_q <= a;
                    if (mis) begin
                        state          <= RESP;
                        bus.resp_valid <= 1'b1;
                        bus.resp_err   <= 1'b1;
                        bus.resp_rdata <= 32'h0;
                    end else begin
                        state    <= ACCESS;
                        cnt      <= is_load ? LD_CNT : 2'd0;
                        ram_ce   <= CHIP_ENABLE;
                        ram_we   <= ~is_load;
                        ram_sel  <= is_load ? 4'b1111 : st_sel;
                        ram_addr <= {bus.req_addr[ADDR_W-1:2], 2'b00};
                        if (!is_load) ram_wdata <= st_data;
                    end
                end
                ACCESS: begin
                    // Stores always enter with cnt=0, so the strobe lasts one cycle.
                    ram_we <= 1'b0;
                    if (cnt == 2'd0) begin
                        state          <= RESP;
                        ram_ce         <= CHIP_DISABLE;
                        ram_sel        <= 4'b0;
                        bus.resp_valid <= 1'b1;
                        bus.resp_err   <= 1'b0;
                        bus.resp_rdata <= (op_q <= 3'd4) ? ld_ext(op_q, off_q, ram_rdata) : 32'h0;
                    end else begin
                        cnt <= cnt - 2'd1;
                    end
                end
                RESP: begin
                    bus.resp_valid <= 1'b0;
                    state          <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed + random bench for lsu_mem_ctrl against a byte-array memory model.
module tb_lsu_mem_ctrl;
    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ram_ce, ram_we;
    logic [3:0]  ram_sel;
    logic [31:0] ram_addr, ram_wdata, ram_rdata;
    int          ncmp = 0;
    int          nfail = 0;

    lsu_mem_ctrl_if #(.ADDR_W(32)) bus ();

    lsu_mem_ctrl #(.RD_LATENCY(LAT), .ADDR_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .ram_ce(ram_ce), .ram_we(ram_we), .ram_sel(ram_sel),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    // Word-organised RAM the DUT talks to.
    logic [31:0] ram_w [16] = '{default: 32'h0};
    assign ram_rdata = ram_ce ? ram_w[ram_addr[5:2]] : 32'h0;
    always @(posedge clk)
        if (ram_ce && ram_we)
            for (int l = 0; l < 4; l++)
                if (ram_sel[l]) ram_w[ram_addr[5:2]][8*l +: 8] <= ram_wdata[8*l +: 8];

    // Reference: byte-addressed memory, big-endian.
    logic [7:0] ref_mem [64] = '{default: 8'h0};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic run(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wd);
        int n, a, idx, cyc, ce_n, we_n, exp_lat;
        logic is_ld, err, addr_ok, sel_ok, wd_ok;
        logic [31:0] exp_d, exp_wd;
        logic [3:0] exp_sel;
        is_ld = (op <= 3'd4);
        n   = (op == 3'd0 || op == 3'd1 || op == 3'd5) ? 1 : (op == 3'd4 || op == 3'd7) ? 4 : 2;
        a   = int'(addr[1:0]);
        idx = int'(addr[5:0]);
        err = (a % n) != 0;
        exp_d = 32'h0;
        if (!err && is_ld) begin
            for (int i = 0; i < n; i++) exp_d = (exp_d << 8) | 32'(ref_mem[idx + i]);
            if (op == 3'd0 && exp_d[7])  exp_d |= 32'hFFFFFF00;
            if (op == 3'd2 && exp_d[15]) exp_d |= 32'hFFFF0000;
        end
        exp_sel = is_ld ? 4'hF : 4'(((1 << n) - 1) << (4 - a - n));
        exp_wd  = (n == 1) ? {4{wd[7:0]}} : (n == 2) ? {2{wd[15:0]}} : wd;
        exp_lat = err ? 1 : is_ld ? LAT + 1 : 2;

        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_op = op; bus.req_addr = addr; bus.req_wdata = wd;
        #1;
        chk("ready_idle", 32'(bus.req_ready), 32'd1);
        chk("stall_at_T", 32'(bus.stall_o), 32'd1);
        cyc = 0; ce_n = 0; we_n = 0; addr_ok = 1; sel_ok = 1; wd_ok = 1;
        do begin
            @(negedge clk);
            cyc++;
            if (ram_ce) begin
                ce_n++;
                if (ram_addr !== {addr[31:2], 2'b00}) addr_ok = 0;
                if (ram_sel !== exp_sel) sel_ok = 0;
            end
            if (ram_we) begin
                we_n++;
                if (ram_wdata !== exp_wd) wd_ok = 0;
            end
            if (!bus.resp_valid) begin
                chk("stall_busy", 32'(bus.stall_o), 32'd1);
                chk("ready_busy", 32'(bus.req_ready), 32'd0);
            end
        end while (!bus.resp_valid && cyc < 20);
        chk("resp_latency", 32'(cyc), 32'(exp_lat));
        chk("resp_err", 32'(bus.resp_err), 32'(err));
        chk("resp_rdata", bus.resp_rdata, exp_d);
        chk("ce_cycles", 32'(ce_n), 32'(err ? 0 : is_ld ? LAT : 1));
        chk("we_cycles", 32'(we_n), 32'((!err && !is_ld) ? 1 : 0));
        chk("ram_addr_const", 32'(addr_ok), 32'd1);
        chk("ram_sel", 32'(sel_ok), 32'd1);
        chk("ram_wdata", 32'(wd_ok), 32'd1);
        chk("stall_resp", 32'(bus.stall_o), 32'd0);
        bus.req_valid = 1'b0;
        @(negedge clk);
        chk("ready_after", 32'(bus.req_ready), 32'd1);
        chk("sel_idle", 32'(ram_sel), 32'd0);
        chk("resp_pulse", 32'(bus.resp_valid), 32'd0);
        if (!err && !is_ld)
            for (int i = 0; i < n; i++) ref_mem[idx + i] = wd[8*(n-1-i) +: 8];
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req_valid = 1'b0; bus.req_op = 3'd0; bus.req_addr = 32'h0; bus.req_wdata = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ce", 32'(ram_ce), 32'd0);
        chk("rst_we", 32'(ram_we), 32'd0);
        chk("rst_sel", 32'(ram_sel), 32'd0);
        chk("rst_addr", ram_addr, 32'h0);
        chk("rst_wdata", ram_wdata, 32'h0);
        chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst_resp_rdata", bus.resp_rdata, 32'h0);
        chk("rst_resp_err", 32'(bus.resp_err), 32'd0);
        chk("rst_ready", 32'(bus.req_ready), 32'd1);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("idle_no_ce", 32'(ram_ce), 32'd0);
            chk("idle_no_stall", 32'(bus.stall_o), 32'd0);
        end

        run(3'd5, 32'h13, 32'h000000A5);   // SB
        run(3'd7, 32'h10, 32'h80FF7F01);   // SW
        run(3'd0, 32'h10, 32'h0);          // LB  -> FFFFFF80
        run(3'd1, 32'h10, 32'h0);          // LBU -> 00000080
        run(3'd2, 32'h12, 32'h0);          // LH  -> 00007F01
        run(3'd3, 32'h10, 32'h0);          // LHU -> 000080FF
        run(3'd4, 32'h10, 32'h0);          // LW
        run(3'd6, 32'h22, 32'h1234BEEF);   // SH lower half
        run(3'd4, 32'h20, 32'h0);
        run(3'd7, 32'h12, 32'hDEADBEEF);   // misaligned SW
        run(3'd2, 32'h11, 32'h0);          // misaligned LH

        // Reset during the first ACCESS cycle of a load.
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_op = 3'd4; bus.req_addr = 32'h10; bus.req_wdata = 32'h0;
        @(negedge clk);
        chk("abort_ce_before", 32'(ram_ce), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_ce_async", 32'(ram_ce), 32'd0);
        chk("abort_we_async", 32'(ram_we), 32'd0);
        bus.req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (LAT + 2) begin
            @(negedge clk);
            chk("abort_no_resp", 32'(bus.resp_valid), 32'd0);
        end
        run(3'd4, 32'h10, 32'h0);

        for (int k = 0; k < 40; k++) begin
            run(3'($urandom_range(0, 7)), 32'($urandom_range(0, 63)), $urandom);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
